// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 key-search slice.
package rc4_pkg;
  localparam int DEF_KEY_WIDTH = 24;
  localparam int DEF_MSG_LEN = 32;
  localparam logic [7:0] CHAR_SPACE = 8'd32;
  localparam logic [7:0] CHAR_A_LO = 8'd97;
  localparam logic [7:0] CHAR_Z_LO = 8'd122;
  typedef enum logic [3:0] {
    IDLE, LAUNCH, WAIT_CORE, READ_REQ, READ_WAIT, CHECK, NEXT_KEY, FOUND, NOT_FOUND
  } ks_state_t;
endpackage

// File: rtl/msg_char_check.sv
// msg_char_check: flags a decrypted byte as lowercase letter or space.
module msg_char_check import rc4_pkg::*; (
  input  logic [7:0] ch,
  output logic       legal
);
  assign legal = (ch == CHAR_SPACE) | (ch >= CHAR_A_LO & ch <= CHAR_Z_LO);
endmodule

// File: rtl/key_search_ctrl.sv
// key_search_ctrl: brute-force key sweep that launches the RC4 pipeline and scans its output.
module key_search_ctrl import rc4_pkg::*; #(
  parameter int                   KEY_WIDTH = DEF_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF),
  parameter int                   MSG_LEN   = DEF_MSG_LEN,
  parameter int                   ADDR_W    = $clog2(MSG_LEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 core_done,
  input  logic [7:0]           d_q,
  output logic                 core_start,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic [ADDR_W-1:0]    d_address,
  output logic                 d_rden,
  output logic                 busy,
  output logic                 found,
  output logic                 not_found
);
  ks_state_t state;
  logic      legal;
  msg_char_check u_check (.ch(d_q), .legal(legal));
  // Outputs are set on the transition into the state that owns them, so they are glitch-free registers.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      secret_key <= '0;
      d_address  <= '0;
      core_start <= 1'b0;
      d_rden     <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      not_found  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      d_rden     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= LAUNCH;
          secret_key <= '0;
          core_start <= 1'b1;
          busy       <= 1'b1;
        end
        LAUNCH: state <= WAIT_CORE;
        WAIT_CORE: if (core_done) begin
          state     <= READ_REQ;
          d_address <= '0;
          d_rden    <= 1'b1;
        end
        READ_REQ: begin
          state  <= READ_WAIT;
          d_rden <= 1'b1;
        end
        READ_WAIT: state <= CHECK;
        CHECK:
          if (!legal) state <= NEXT_KEY;
          else if (d_address == ADDR_W'(MSG_LEN - 1)) begin
            state <= FOUND;
            found <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state     <= READ_REQ;
            d_address <= d_address + ADDR_W'(1);
            d_rden    <= 1'b1;
          end
        NEXT_KEY:
          if (secret_key == KEY_MAX) begin
            state     <= NOT_FOUND;
            not_found <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state      <= LAUNCH;
            secret_key <= secret_key + KEY_WIDTH'(1);
            core_start <= 1'b1;
          end
        FOUND, NOT_FOUND: state <= state;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_key_search_ctrl.sv
// tb_key_search_ctrl: randomized scenarios against a per-key first-bad-byte reference model.
module tb_key_search_ctrl;
  localparam int KW = 24, ML = 32, AW = 5, KMAX = 3, DELAY = 10;
  logic clk = 0, reset = 0, start = 0, core_done = 0;
  logic [7:0] d_q = '0;
  logic core_start, d_rden, busy, found, not_found;
  logic [KW-1:0] secret_key;
  logic [AW-1:0] d_address;
  logic [AW-1:0] addr_r = '0;
  logic [7:0] mem_img [4][ML];
  int errors = 0, checks = 0;
  int launches, early, first_key, st;
  int reads [4];
  bit e_found;
  int e_key, e_launch;
  int e_reads [4];

  key_search_ctrl #(.KEY_WIDTH(KW), .KEY_MAX(KW'(KMAX)), .MSG_LEN(ML), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .core_done(core_done), .d_q(d_q),
    .core_start(core_start), .secret_key(secret_key), .d_address(d_address), .d_rden(d_rden),
    .busy(busy), .found(found), .not_found(not_found));

  always #5 clk = ~clk;

  // Message RAM: registered address then registered data, one image per key.
  always @(posedge clk) begin
    if (d_rden) addr_r <= d_address;
    d_q <= mem_img[secret_key[1:0]][addr_r];
  end

  function automatic bit legal_ch(input logic [7:0] b);
    return b == 8'd32 || (b >= 8'd97 && b <= 8'd122);
  endfunction

  function automatic logic [7:0] rand_legal();
    int r = $urandom_range(0, 26);
    return r == 26 ? 8'd32 : 8'(97 + r);
  endfunction

  function automatic logic [7:0] rand_illegal();
    logic [7:0] b = 8'($urandom);
    while (legal_ch(b)) b = 8'($urandom);
    return b;
  endfunction

  task automatic fill_legal();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < ML; i++) mem_img[k][i] = rand_legal();
  endtask

  // Keys are tried in order; each key reads up to its first illegal byte; first clean key wins.
  function automatic void model();
    e_found = 0; e_key = KMAX; e_launch = KMAX + 1;
    for (int k = 0; k < 4; k++) e_reads[k] = 0;
    for (int k = 0; k <= KMAX && !e_found; k++) begin
      int n = ML;
      bit bad = 0;
      for (int i = ML - 1; i >= 0; i--)
        if (!legal_ch(mem_img[k][i])) begin n = i + 1; bad = 1; end
      e_reads[k] = n;
      if (!bad) begin e_found = 1; e_key = k; e_launch = k + 1; end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 0; start = 0; core_done = 0;
    @(negedge clk); reset = 1;
  endtask

  // Plays the pipeline: core_done DELAY cycles after each core_start. status 0=timeout 1=done 2=aborted.
  task automatic run_search(input bit spur_launch, input bit spur_scan, input int abort_key, output int status);
    int cnt = 0;
    bit prev = 0;
    status = 0; launches = 0; early = 0; first_key = -1;
    for (int k = 0; k < 4; k++) reads[k] = 0;
    @(negedge clk); start = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); start = 0; core_done = 0;
      if (found || not_found) begin status = 1; return; end
      if (abort_key >= 0 && d_rden && prev && int'(secret_key) == abort_key) begin status = 2; return; end
      if (core_start) begin
        if (launches == 0) first_key = int'(secret_key);
        launches++; cnt = DELAY;
        if (spur_launch && launches == 1) core_done = 1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) core_done = 1;
      end
      if (d_rden && !prev) begin
        if (cnt > 0) early++;
        reads[secret_key[1:0]]++;
        if (spur_scan) core_done = 1;
      end
      prev = d_rden;
    end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    checks++; if ({core_start, d_rden, busy, found, not_found, secret_key, d_address} !== '0) begin errors++; $display("FAIL reset_outputs: got cs=%b rd=%b busy=%b f=%b nf=%b key=%0d addr=%0d want all 0", core_start, d_rden, busy, found, not_found, secret_key, d_address); end
    reset = 1;
    repeat (3) @(negedge clk);
    checks++; if ({core_start, busy} !== 2'b00) begin errors++; $display("FAIL idle_hold: got cs=%b busy=%b want 0 0", core_start, busy); end
  endtask

  task automatic test_all_legal();
    for (int k = 0; k < 4; k++) for (int i = 0; i < ML; i++) mem_img[k][i] = 8'd97;
    do_reset();
    run_search(0, 0, -1, st);
    checks++; if (st != 1) begin errors++; $display("FAIL all_legal_timeout: got status %0d want 1", st); end
    checks++; if (found !== 1'b1 || secret_key !== 0) begin errors++; $display("FAIL all_legal_found: got found=%b key=%0d want 1 0", found, secret_key); end
    checks++; if (reads[0] != 32) begin errors++; $display("FAIL all_legal_reads: got %0d want 32", reads[0]); end
    checks++; if (busy !== 1'b0 || launches != 1) begin errors++; $display("FAIL all_legal_busy: got busy=%b launches=%0d want 0 1", busy, launches); end
  endtask

  task automatic test_early_exit();
    fill_legal();
    for (int k = 0; k < 3; k++) mem_img[k][5] = 8'd123;
    do_reset();
    run_search(0, 0, -1, st);
    for (int k = 0; k < 3; k++) begin
      checks++; if (reads[k] != 6) begin errors++; $display("FAIL early_exit_reads key %0d: got %0d want 6", k, reads[k]); end
    end
    checks++; if (launches != 4) begin errors++; $display("FAIL early_exit_launches: got %0d want 4", launches); end
    checks++; if (st != 1 || found !== 1'b1 || secret_key !== 3) begin errors++; $display("FAIL early_exit_result: got st=%0d found=%b key=%0d want 1 1 3", st, found, secret_key); end
  endtask

  task automatic test_boundary();
    logic [7:0] vals [6] = '{8'd32, 8'd97, 8'd122, 8'd31, 8'd96, 8'd123};
    int want_key [6] = '{0, 0, 0, 1, 1, 1};
    for (int v = 0; v < 6; v++) begin
      fill_legal();
      mem_img[0][$urandom_range(0, ML - 1)] = vals[v];
      do_reset();
      run_search(0, 0, -1, st);
      checks++; if (st != 1 || found !== 1'b1 || int'(secret_key) != want_key[v]) begin errors++; $display("FAIL boundary byte %0d: got st=%0d found=%b key=%0d want 1 1 %0d", vals[v], st, found, secret_key, want_key[v]); end
    end
  endtask

  task automatic test_not_found();
    int extra = 0;
    fill_legal();
    for (int k = 0; k < 4; k++) mem_img[k][0] = 8'd0;
    do_reset();
    run_search(0, 0, -1, st);
    checks++; if (st != 1 || not_found !== 1'b1 || found !== 1'b0) begin errors++; $display("FAIL not_found_flag: got st=%0d nf=%b f=%b want 1 1 0", st, not_found, found); end
    checks++; if (launches != 4 || reads[3] != 1) begin errors++; $display("FAIL not_found_launches: got %0d reads3=%0d want 4 1", launches, reads[3]); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); start = c[0]; core_done = c[1];
      if (core_start) extra++;
    end
    start = 0; core_done = 0;
    checks++; if (extra != 0 || not_found !== 1'b1 || secret_key !== 3 || busy !== 1'b0) begin errors++; $display("FAIL not_found_hold: got extra=%0d nf=%b key=%0d busy=%b want 0 1 3 0", extra, not_found, secret_key, busy); end
  endtask

  task automatic test_reset_mid();
    fill_legal();
    mem_img[0][3] = 8'd0; mem_img[1][7] = 8'd200;
    do_reset();
    run_search(0, 0, 2, st);
    checks++; if (st != 2) begin errors++; $display("FAIL reset_mid_reach: got status %0d want 2", st); end
    reset = 0;
    @(negedge clk);
    checks++; if ({core_start, d_rden, busy, found, not_found, secret_key, d_address} !== '0) begin errors++; $display("FAIL reset_mid_outputs: got cs=%b rd=%b busy=%b key=%0d addr=%0d want all 0", core_start, d_rden, busy, secret_key, d_address); end
    reset = 1;
    model();
    run_search(0, 0, -1, st);
    checks++; if (first_key != 0 || reads[0] != e_reads[0]) begin errors++; $display("FAIL reset_mid_restart: got first=%0d reads0=%0d want 0 %0d", first_key, reads[0], e_reads[0]); end
    checks++; if (found !== 1'b1 || int'(secret_key) != e_key) begin errors++; $display("FAIL reset_mid_result: got found=%b key=%0d want 1 %0d", found, secret_key, e_key); end
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk); core_done = 1;
    @(negedge clk); core_done = 0;
    repeat (3) @(negedge clk);
    checks++; if ({core_start, d_rden, busy} !== 3'b000) begin errors++; $display("FAIL spurious_idle: got cs=%b rd=%b busy=%b want 0 0 0", core_start, d_rden, busy); end
    fill_legal();
    run_search(1, 0, -1, st);
    checks++; if (early != 0) begin errors++; $display("FAIL spurious_launch_early: got %0d early reads want 0", early); end
    checks++; if (st != 1 || found !== 1'b1 || secret_key !== 0 || launches != 1) begin errors++; $display("FAIL spurious_launch_result: got st=%0d found=%b key=%0d launches=%0d want 1 1 0 1", st, found, secret_key, launches); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      fill_legal();
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) != 0) mem_img[k][$urandom_range(0, ML - 1)] = rand_illegal();
      model();
      do_reset();
      run_search(0, bit'($urandom_range(0, 1)), -1, st);
      checks++; if (st != 1 || found !== e_found || not_found !== !e_found || int'(secret_key) != e_key) begin errors++; $display("FAIL random %0d result: got st=%0d f=%b nf=%b key=%0d want f=%b key=%0d", n, st, found, not_found, secret_key, e_found, e_key); end
      checks++; if (launches != e_launch || early != 0) begin errors++; $display("FAIL random %0d launches: got %0d early=%0d want %0d 0", n, launches, early, e_launch); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (reads[k] != e_reads[k]) begin errors++; $display("FAIL random %0d reads key %0d: got %0d want %0d", n, k, reads[k], e_reads[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_legal();
    test_early_exit();
    test_boundary();
    test_not_found();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
